// File: rtl/ysyx_23060236_csr_trap_unit_pkg.sv
// Shared constants for the ysyx_23060236 machine-mode CSR file and trap unit:
// CSR addresses, csr_op encodings, trap cause codes and status bit positions.
package ysyx_23060236_csr_trap_unit_pkg;

    localparam int CSR_XLEN = 32;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_SATP      = 12'h180;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
    localparam logic [4:0] CAUSE_EBREAK    = 5'd3;
    localparam logic [4:0] CAUSE_ECALL     = 5'd11;
    localparam logic [4:0] CAUSE_TIMER_IRQ = 5'd7;
    localparam logic [4:0] CAUSE_EXT_IRQ   = 5'd11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIX_TIMER_BIT    = 7;
    localparam int MIX_EXT_BIT      = 11;

    // Zicsr read-modify-write: the new value derived from the old CSR value.
    function automatic logic [CSR_XLEN-1:0] csrWriteValue(
        input csr_op_e             op,
        input logic [CSR_XLEN-1:0] oldValue,
        input logic [CSR_XLEN-1:0] operand
    );
        case (op)
            CSR_OP_RW: csrWriteValue = operand;
            CSR_OP_RS: csrWriteValue = oldValue | operand;
            CSR_OP_RC: csrWriteValue = oldValue & ~operand;
            default:   csrWriteValue = oldValue;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060236_csr_counter.sv
// WIDTH-bit performance counter exposed as two 32-bit CSR halves. A software
// write to either half takes precedence over the increment for that half.
module ysyx_23060236_csr_counter
    import ysyx_23060236_csr_trap_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_inc,
    input  logic                i_loWe,
    input  logic                i_hiWe,
    input  logic [CSR_XLEN-1:0] i_wdata,
    output logic [CSR_XLEN-1:0] o_lo,
    output logic [CSR_XLEN-1:0] o_hi
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_incremented;

    assign w_incremented = r_count + {{(WIDTH-1){1'b0}}, i_inc};

    // Writing the low half freezes the counter; writing the high half keeps the low half counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_loWe) begin
            r_count[CSR_XLEN-1:0] <= i_wdata;
        end else if (i_hiWe) begin
            r_count <= {i_wdata[WIDTH-CSR_XLEN-1:0], w_incremented[CSR_XLEN-1:0]};
        end else begin
            r_count <= w_incremented;
        end
    end

    assign o_lo = r_count[CSR_XLEN-1:0];
    assign o_hi = CSR_XLEN'(r_count[WIDTH-1:CSR_XLEN]);

endmodule

// File: rtl/ysyx_23060236_csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR read/write, counters,
// interrupt/exception entry with MIE/MPIE stacking, mret, and PC redirect.
module ysyx_23060236_csr_trap_unit
    import ysyx_23060236_csr_trap_unit_pkg::*;
#(
    parameter int          CNT_WIDTH = 64,
    parameter bit          HAS_SATP  = 1'b1,
    parameter bit          VECTORED  = 1'b1,
    parameter logic [31:0] MVENDORID = 32'h79737978,
    parameter logic [31:0] MARCHID   = 32'h015fdf0c
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [11:0] i_csrAddr,
    input  logic [1:0]  i_csrOp,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic        i_instEcall,
    input  logic        i_instEbreak,
    input  logic        i_instIllegal,
    input  logic        i_instMret,
    input  logic [31:0] i_epc,
    input  logic [31:0] i_tval,
    input  logic        i_irqTimer,
    input  logic        i_irqExt,
    output logic [31:0] o_jump,
    output logic        o_jumpEn,
    output logic        o_csrIllegal,
    output logic        o_mmuOn,
    output logic [19:0] o_ppn
);

    logic        r_mstatusMie, r_mstatusMpie;
    logic        r_mieMtie, r_mieMeie, r_mipMtip, r_mipMeip;
    logic        r_mcauseInt;
    logic [4:0]  r_mcauseCode;
    logic [31:0] r_mtvec, r_mepc, r_mtval, r_mscratch, r_satp;

    csr_op_e     w_csrOp;
    logic        w_implemented, w_csrIllegal, w_csrWe, w_mret;
    logic        w_trap, w_trapInt, w_trapIllegal, w_vectorMode;
    logic [4:0]  w_trapCode;
    logic [31:0] w_rdata, w_newValue, w_trapBase;
    logic [31:0] w_mcycleLo, w_mcycleHi, w_minstretLo, w_minstretHi;

    assign w_csrOp = csr_op_e'(i_csrOp);

    // Combinational CSR read of the addressed register, flagging unknown addresses.
    always_comb begin
        w_rdata       = '0;
        w_implemented = 1'b1;
        case (i_csrAddr)
            CSR_MSTATUS:   w_rdata = {19'b0, 2'b11, 3'b0, r_mstatusMpie, 3'b0, r_mstatusMie, 3'b0};
            CSR_MIE:       w_rdata = {20'b0, r_mieMeie, 3'b0, r_mieMtie, 7'b0};
            CSR_MIP:       w_rdata = {20'b0, r_mipMeip, 3'b0, r_mipMtip, 7'b0};
            CSR_MTVEC:     w_rdata = VECTORED ? r_mtvec : {r_mtvec[31:2], 2'b00};
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = {r_mcauseInt, 26'b0, r_mcauseCode};
            CSR_MTVAL:     w_rdata = r_mtval;
            CSR_SATP:      w_rdata = r_satp;
            CSR_MCYCLE:    w_rdata = w_mcycleLo;
            CSR_MCYCLEH:   w_rdata = w_mcycleHi;
            CSR_MINSTRET:  w_rdata = w_minstretLo;
            CSR_MINSTRETH: w_rdata = w_minstretHi;
            CSR_MVENDORID: w_rdata = MVENDORID;
            CSR_MARCHID:   w_rdata = MARCHID;
            CSR_MIMPID:    w_rdata = '0;
            CSR_MHARTID:   w_rdata = '0;
            default:       w_implemented = 1'b0;
        endcase
    end

    assign o_rdata      = w_rdata;
    assign w_csrIllegal = (w_csrOp != CSR_OP_NONE) && (!w_implemented || i_csrAddr[11:4] == 8'hF1);
    assign o_csrIllegal = w_csrIllegal;

    // Trap selection by priority: ext irq, timer irq, illegal, ebreak, ecall.
    always_comb begin
        w_trap        = 1'b0;
        w_trapInt     = 1'b0;
        w_trapIllegal = 1'b0;
        w_trapCode    = '0;
        if (i_valid) begin
            if (r_mstatusMie && r_mieMeie && r_mipMeip) begin
                w_trap = 1'b1; w_trapInt = 1'b1; w_trapCode = CAUSE_EXT_IRQ;
            end else if (r_mstatusMie && r_mieMtie && r_mipMtip) begin
                w_trap = 1'b1; w_trapInt = 1'b1; w_trapCode = CAUSE_TIMER_IRQ;
            end else if (i_instIllegal || w_csrIllegal) begin
                w_trap = 1'b1; w_trapIllegal = 1'b1; w_trapCode = CAUSE_ILLEGAL;
            end else if (i_instEbreak) begin
                w_trap = 1'b1; w_trapCode = CAUSE_EBREAK;
            end else if (i_instEcall) begin
                w_trap = 1'b1; w_trapCode = CAUSE_ECALL;
            end
        end
    end

    assign w_vectorMode = VECTORED && (r_mtvec[1:0] == 2'b01);
    assign w_trapBase   = {r_mtvec[31:2], 2'b00};
    assign w_mret       = i_valid && i_instMret && !w_trap;
    assign w_csrWe      = i_valid && (w_csrOp != CSR_OP_NONE) && !w_trap && !w_csrIllegal;
    assign w_newValue   = csrWriteValue(w_csrOp, w_rdata, i_wdata);

    // PC redirect from the pre-edge mtvec/mepc on trap entry or mret.
    always_comb begin
        o_jump   = '0;
        o_jumpEn = 1'b0;
        if (w_trap) begin
            o_jumpEn = 1'b1;
            o_jump   = (w_trapInt && w_vectorMode) ? w_trapBase + {25'b0, w_trapCode, 2'b00} : w_trapBase;
        end else if (w_mret) begin
            o_jumpEn = 1'b1;
            o_jump   = r_mepc;
        end
    end

    // CSR state: interrupt sampling, software writes, then trap/mret stacking.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mstatusMie  <= 1'b0;
            r_mstatusMpie <= 1'b0;
            r_mieMtie     <= 1'b0;
            r_mieMeie     <= 1'b0;
            r_mipMtip     <= 1'b0;
            r_mipMeip     <= 1'b0;
            r_mcauseInt   <= 1'b0;
            r_mcauseCode  <= '0;
            r_mtvec       <= '0;
            r_mepc        <= '0;
            r_mtval       <= '0;
            r_mscratch    <= '0;
            r_satp        <= '0;
        end else begin
            r_mipMtip <= i_irqTimer;
            r_mipMeip <= i_irqExt;
            if (w_csrWe) begin
                case (i_csrAddr)
                    CSR_MSTATUS: begin
                        r_mstatusMie  <= w_newValue[MSTATUS_MIE_BIT];
                        r_mstatusMpie <= w_newValue[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE: begin
                        r_mieMtie <= w_newValue[MIX_TIMER_BIT];
                        r_mieMeie <= w_newValue[MIX_EXT_BIT];
                    end
                    CSR_MTVEC:    r_mtvec    <= w_newValue;
                    CSR_MSCRATCH: r_mscratch <= w_newValue;
                    CSR_MEPC:     r_mepc     <= w_newValue;
                    CSR_MTVAL:    r_mtval    <= w_newValue;
                    CSR_MCAUSE: begin
                        r_mcauseInt  <= w_newValue[31];
                        r_mcauseCode <= w_newValue[4:0];
                    end
                    CSR_SATP: if (HAS_SATP) r_satp <= w_newValue;
                    default: ;
                endcase
            end
            if (w_trap) begin
                r_mepc        <= i_epc;
                r_mcauseInt   <= w_trapInt;
                r_mcauseCode  <= w_trapCode;
                r_mtval       <= w_trapIllegal ? i_tval : 32'h0;
                r_mstatusMpie <= r_mstatusMie;
                r_mstatusMie  <= 1'b0;
            end else if (w_mret) begin
                r_mstatusMie  <= r_mstatusMpie;
                r_mstatusMpie <= 1'b1;
            end
        end
    end

    assign o_mmuOn = r_satp[31];
    assign o_ppn   = r_satp[19:0];

    ysyx_23060236_csr_counter #(.WIDTH(CNT_WIDTH)) u_mcycle (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (1'b1),
        .i_loWe  (w_csrWe && i_csrAddr == CSR_MCYCLE),
        .i_hiWe  (w_csrWe && i_csrAddr == CSR_MCYCLEH),
        .i_wdata (w_newValue),
        .o_lo    (w_mcycleLo),
        .o_hi    (w_mcycleHi)
    );

    ysyx_23060236_csr_counter #(.WIDTH(CNT_WIDTH)) u_minstret (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (i_valid && !w_trap),
        .i_loWe  (w_csrWe && i_csrAddr == CSR_MINSTRET),
        .i_hiWe  (w_csrWe && i_csrAddr == CSR_MINSTRETH),
        .i_wdata (w_newValue),
        .o_lo    (w_minstretLo),
        .o_hi    (w_minstretHi)
    );

endmodule

// File: tb/tb_ysyx_23060236_csr_trap_unit.sv
// Directed bench for the CSR file and trap unit: a vector table of CSR
// accesses and traps followed by interrupt, counter and reset sequences.
module tb_ysyx_23060236_csr_trap_unit;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;
    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_ECALL = 4'b1000;
    localparam logic [3:0] C_EBRK  = 4'b0100;
    localparam logic [3:0] C_ILL   = 4'b0010;
    localparam logic [3:0] C_MRET  = 4'b0001;
    localparam logic [31:0] BASE   = 32'h80001000;

    typedef struct {
        logic        valid;
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [3:0]  cls;
        logic [31:0] epc;
        logic [31:0] tval;
        logic        chkR;
        logic [31:0] expRdata;
        logic        expIll;
        logic        expJen;
        logic [31:0] expJump;
    } vec_t;

    logic        clock, reset, valid;
    logic [11:0] csrAddr;
    logic [1:0]  csrOp;
    logic [31:0] wdata, rdata, epc, tval, jump;
    logic        instEcall, instEbreak, instIllegal, instMret;
    logic        irqTimer, irqExt, jumpEn, csrIllegal, mmuOn;
    logic [19:0] ppn;

    int checks = 0;
    int errors = 0;
    int stepNo = 0;
    vec_t vecs[$];

    ysyx_23060236_csr_trap_unit dut (
        .clock        (clock),
        .reset        (reset),
        .i_valid      (valid),
        .i_csrAddr    (csrAddr),
        .i_csrOp      (csrOp),
        .i_wdata      (wdata),
        .o_rdata      (rdata),
        .i_instEcall  (instEcall),
        .i_instEbreak (instEbreak),
        .i_instIllegal(instIllegal),
        .i_instMret   (instMret),
        .i_epc        (epc),
        .i_tval       (tval),
        .i_irqTimer   (irqTimer),
        .i_irqExt     (irqExt),
        .o_jump       (jump),
        .o_jumpEn     (jumpEn),
        .o_csrIllegal (csrIllegal),
        .o_mmuOn      (mmuOn),
        .o_ppn        (ppn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic v, input logic [11:0] a, input logic [1:0] op,
                                input logic [31:0] wd, input logic [3:0] cls, input logic [31:0] pc,
                                input logic [31:0] tv, input logic chk, input logic [31:0] expR,
                                input logic ill, input logic jen, input logic [31:0] jmp);
        vec_t r;
        r.valid = v; r.addr = a; r.op = op; r.wdata = wd; r.cls = cls; r.epc = pc; r.tval = tv;
        r.chkR = chk; r.expRdata = expR; r.expIll = ill; r.expJen = jen; r.expJump = jmp;
        return r;
    endfunction

    function automatic vec_t rd(input logic [11:0] a, input logic [31:0] e);
        return mk(1'b0, a, OP_NONE, 32'h0, C_NONE, 32'h0, 32'h0, 1'b1, e, 1'b0, 1'b0, 32'h0);
    endfunction

    task automatic applyStimulus(input vec_t v);
        valid   = v.valid;
        csrAddr = v.addr;
        csrOp   = v.op;
        wdata   = v.wdata;
        {instEcall, instEbreak, instIllegal, instMret} = v.cls;
        epc     = v.epc;
        tval    = v.tval;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at step %0d: got 0x%08h, expected 0x%08h", name, stepNo, actual, expected);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        #1;
        stepNo++;
        if (v.chkR) checkOutput("rdata", rdata, v.expRdata);
        checkOutput("csrIllegal", {31'b0, csrIllegal}, {31'b0, v.expIll});
        checkOutput("jumpEn", {31'b0, jumpEn}, {31'b0, v.expJen});
        if (v.expJen) checkOutput("jump", jump, v.expJump);
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Basic CSR read/modify/write, ID registers, satp, mret and synchronous exceptions
        vecs.push_back(rd(12'h300, 32'h00001800));
        vecs.push_back(mk(1, 12'h300, OP_RS, 32'h8, C_NONE, 0, 0, 1, 32'h00001800, 0, 0, 0));
        vecs.push_back(mk(1, 12'h300, OP_RC, 32'h8, C_NONE, 0, 0, 1, 32'h00001808, 0, 0, 0));
        vecs.push_back(rd(12'h300, 32'h00001800));
        vecs.push_back(mk(1, 12'h340, OP_RW, 32'hDEADBEEF, C_NONE, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h340, OP_RS, 32'h00000100, C_NONE, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(1, 12'h340, OP_RC, 32'h000000FF, C_NONE, 0, 0, 1, 32'hDEADBFEF, 0, 0, 0));
        vecs.push_back(rd(12'h340, 32'hDEADBF00));
        vecs.push_back(mk(1, 12'h305, OP_RW, 32'h80001001, C_NONE, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(rd(12'h305, 32'h80001001));
        vecs.push_back(rd(12'hF11, 32'h79737978));
        vecs.push_back(rd(12'hF12, 32'h015FDF0C));
        vecs.push_back(mk(1, 12'h300, OP_RW, 32'hFFFFFFFF, C_NONE, 0, 0, 1, 32'h00001800, 0, 0, 0));
        vecs.push_back(rd(12'h300, 32'h00001888));
        vecs.push_back(mk(1, 12'h300, OP_RW, 32'h0, C_NONE, 0, 0, 1, 32'h00001888, 0, 0, 0));
        vecs.push_back(mk(1, 12'h304, OP_RW, 32'hFFFFFFFF, C_NONE, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h304, OP_RW, 32'h0, C_NONE, 0, 0, 1, 32'h00000880, 0, 0, 0));
        vecs.push_back(mk(0, 12'h7C0, OP_RS, 32'h1, C_NONE, 0, 0, 1, 32'h0, 1, 0, 0));
        vecs.push_back(mk(1, 12'h344, OP_RW, 32'hFFFFFFFF, C_NONE, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(rd(12'h344, 32'h0));
        vecs.push_back(mk(1, 12'h180, OP_RW, 32'h80012345, C_NONE, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(rd(12'h180, 32'h80012345));
        vecs.push_back(mk(1, 12'h341, OP_RW, 32'h80000100, C_NONE, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h300, OP_NONE, 32'h0, C_MRET, 0, 0, 1, 32'h00001800, 0, 1, 32'h80000100));
        vecs.push_back(rd(12'h300, 32'h00001880));
        vecs.push_back(mk(1, 12'h340, OP_RW, 32'h12345678, C_ECALL, 32'h80000200, 0, 1, 32'hDEADBF00, 0, 1, BASE));
        vecs.push_back(rd(12'h342, 32'h0000000B));
        vecs.push_back(rd(12'h340, 32'hDEADBF00));
        vecs.push_back(rd(12'h341, 32'h80000200));
        vecs.push_back(rd(12'h300, 32'h00001800));
        vecs.push_back(mk(1, 12'h300, OP_NONE, 0, C_EBRK, 32'h80000300, 32'h00100073, 1, 32'h00001800, 0, 1, BASE));
        vecs.push_back(rd(12'h342, 32'h00000003));
        vecs.push_back(rd(12'h343, 32'h0));
        vecs.push_back(mk(1, 12'h300, OP_NONE, 0, C_ILL, 32'h80000400, 32'hFFFFFFFF, 1, 32'h00001800, 0, 1, BASE));
        vecs.push_back(rd(12'h343, 32'hFFFFFFFF));
        vecs.push_back(rd(12'h342, 32'h00000002));
        vecs.push_back(mk(1, 12'hF11, OP_RW, 32'h5, C_NONE, 32'h80000500, 32'h34511073, 1, 32'h79737978, 1, 1, BASE));
        vecs.push_back(rd(12'h343, 32'h34511073));
        vecs.push_back(rd(12'h341, 32'h80000500));
        vecs.push_back(rd(12'h342, 32'h00000002));
        vecs.push_back(mk(1, 12'h300, OP_NONE, 0, C_ECALL | C_EBRK, 32'h80000600, 0, 1, 32'h00001800, 0, 1, BASE));
        vecs.push_back(rd(12'h342, 32'h00000003));
        vecs.push_back(mk(0, 12'h300, OP_NONE, 0, C_ECALL, 32'h80000680, 0, 1, 32'h00001800, 0, 0, 0));
        vecs.push_back(rd(12'h342, 32'h00000003));

        applyStimulus(mk(0, 12'h300, OP_NONE, 0, C_NONE, 0, 0, 0, 0, 0, 0, 0));
        irqTimer = 1'b0;
        irqExt   = 1'b0;
        reset    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        $display("[TB] reset released");
        checkOutput("resetMstatus", rdata, 32'h00001800);
        checkOutput("resetMmuOn", {31'b0, mmuOn}, 32'h0);
        checkOutput("resetPpn", {12'b0, ppn}, 32'h0);
        checkOutput("resetJumpEn", {31'b0, jumpEn}, 32'h0);

        foreach (vecs[i]) runVec(vecs[i]);
        checkOutput("mmuOn", {31'b0, mmuOn}, 32'h1);
        checkOutput("ppn", {12'b0, ppn}, 32'h00012345);

        // Timer interrupt through vectored mtvec, then mret restores MIE
        runVec(mk(1, 12'h300, OP_RS, 32'h8, C_NONE, 0, 0, 1, 32'h00001800, 0, 0, 0));
        runVec(mk(1, 12'h304, OP_RW, 32'h80, C_NONE, 0, 0, 1, 32'h0, 0, 0, 0));
        irqTimer = 1'b1;
        runVec(rd(12'h344, 32'h0));
        irqTimer = 1'b0;
        runVec(mk(1, 12'h344, OP_NONE, 0, C_NONE, 32'h80000700, 0, 1, 32'h00000080, 0, 1, 32'h8000101C));
        runVec(rd(12'h342, 32'h80000007));
        runVec(rd(12'h300, 32'h00001880));
        runVec(rd(12'h341, 32'h80000700));
        runVec(rd(12'h343, 32'h0));
        runVec(mk(1, 12'h300, OP_NONE, 0, C_MRET, 0, 0, 1, 32'h00001880, 0, 1, 32'h80000700));
        runVec(rd(12'h300, 32'h00001888));

        // Masked external interrupt, then external beats timer once enabled
        irqExt = 1'b1;
        runVec(rd(12'h344, 32'h0));
        runVec(mk(1, 12'h344, OP_NONE, 0, C_NONE, 0, 0, 1, 32'h00000800, 0, 0, 0));
        irqTimer = 1'b1;
        runVec(mk(1, 12'h304, OP_RW, 32'h880, C_NONE, 0, 0, 1, 32'h00000080, 0, 0, 0));
        runVec(mk(1, 12'h344, OP_NONE, 0, C_NONE, 32'h80000800, 0, 1, 32'h00000880, 0, 1, 32'h8000102C));
        irqTimer = 1'b0;
        irqExt   = 1'b0;
        runVec(rd(12'h342, 32'h8000000B));
        runVec(rd(12'h300, 32'h00001880));
        runVec(mk(1, 12'h304, OP_RW, 32'h0, C_NONE, 0, 0, 1, 32'h00000880, 0, 0, 0));

        // minstret: software write wins, trapped instruction does not retire
        runVec(mk(1, 12'hB02, OP_RW, 32'd100, C_NONE, 0, 0, 0, 0, 0, 0, 0));
        runVec(rd(12'hB02, 32'd100));
        runVec(rd(12'hB82, 32'd0));
        runVec(mk(1, 12'h300, OP_NONE, 0, C_ECALL, 32'h80000900, 0, 1, 32'h00001880, 0, 1, BASE));
        runVec(rd(12'hB02, 32'd100));
        runVec(mk(1, 12'hB02, OP_NONE, 0, C_NONE, 0, 0, 1, 32'd100, 0, 0, 0));
        runVec(rd(12'hB02, 32'd101));

        // mcycle low-word wrap carries into the high half
        runVec(mk(1, 12'hB80, OP_RW, 32'h0, C_NONE, 0, 0, 0, 0, 0, 0, 0));
        runVec(mk(1, 12'hB00, OP_RW, 32'hFFFFFFFF, C_NONE, 0, 0, 0, 0, 0, 0, 0));
        runVec(rd(12'hB00, 32'hFFFFFFFF));
        runVec(rd(12'hB80, 32'h1));
        runVec(rd(12'hB00, 32'h1));
        runVec(rd(12'hB80, 32'h1));

        // Reset asserted during a trapping instruction leaves only reset state
        applyStimulus(mk(1, 12'h300, OP_NONE, 0, C_ECALL, 32'h80000A00, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        runVec(rd(12'h342, 32'h0));
        runVec(rd(12'h341, 32'h0));
        runVec(rd(12'h300, 32'h00001800));
        runVec(rd(12'h305, 32'h0));
        runVec(rd(12'hB02, 32'h0));
        checkOutput("postResetMmuOn", {31'b0, mmuOn}, 32'h0);
        checkOutput("postResetPpn", {12'b0, ppn}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
